time_set_controller: RTL and testbench

Sequences manual time setting for the clock counters (hour, minute, second). Converts debounced MODE/UP/DOWN button levels into per-field `ctrl_set_*` levels and shared single-cycle `inc`/`dec` pulses, with press-and-hold auto-repeat, an idle timeout back to run mode, and a blink enable for the display. Sits between the button debouncers / 1 ms prescaler and the second/minute/hour counter chain.

---
 rtl/clock_pkg.sv | 34 +++
 rtl/time_set_controller_if.sv | 31 +++
 rtl/time_set_controller_btn_repeat.sv | 71 +++++++
 rtl/time_set_controller.sv | 132 +++++++++++++
 tb/tb_time_set_controller.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the clock set-time logic.
//   - FSM state encoding (RUN / SET_HOUR / SET_MIN / SET_SEC)
//   - field_sel codes (identical to the state encoding)
//   - default millisecond constants for hold, repeat, timeout and blink
//   - next_field(): MODE-button advance order
package clock_pkg;

  typedef logic [1:0] field_t;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_SET_HOUR = 2'd1;
  localparam logic [1:0] ST_SET_MIN  = 2'd2;
  localparam logic [1:0] ST_SET_SEC  = 2'd3;

  localparam field_t FIELD_RUN  = ST_RUN;
  localparam field_t FIELD_HOUR = ST_SET_HOUR;
  localparam field_t FIELD_MIN  = ST_SET_MIN;
  localparam field_t FIELD_SEC  = ST_SET_SEC;

  localparam int DEF_HOLD_MS    = 500;
  localparam int DEF_REPEAT_MS  = 100;
  localparam int DEF_TIMEOUT_MS = 10000;
  localparam int DEF_BLINK_MS   = 250;

  function automatic logic [1:0] next_field(input logic [1:0] s);
    case (s)
      ST_RUN:      next_field = ST_SET_HOUR;
      ST_SET_HOUR: next_field = ST_SET_MIN;
      ST_SET_MIN:  next_field = ST_SET_SEC;
      default:     next_field = ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// time_set_controller_if: bundle between the button/prescaler side and the
// time-set controller.
//   tick_ms, btn_mode, btn_up, btn_down : toward the controller
//   ctrl_set_hour/min/sec, inc, dec,
//   field_sel, blink_on                 : from the controller
// master = button/prescaler side, slave = controller.
interface time_set_controller_if;
  import clock_pkg::*;

  logic   tick_ms;
  logic   btn_mode;
  logic   btn_up;
  logic   btn_down;
  logic   ctrl_set_hour;
  logic   ctrl_set_min;
  logic   ctrl_set_sec;
  logic   inc;
  logic   dec;
  field_t field_sel;
  logic   blink_on;

  modport master (
    output tick_ms, btn_mode, btn_up, btn_down,
    input  ctrl_set_hour, ctrl_set_min, ctrl_set_sec, inc, dec, field_sel, blink_on
  );

  modport slave (
    input  tick_ms, btn_mode, btn_up, btn_down,
    output ctrl_set_hour, ctrl_set_min, ctrl_set_sec, inc, dec, field_sel, blink_on
  );
endinterface

// File: rtl/time_set_controller_btn_repeat.sv
// btn_repeat: edge detect plus press-and-hold auto-repeat for one button.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick_ms    : 1 ms strobe
//   btn        : debounced button level
//   clear      : holds the hold/repeat counters at zero and drops any pulse
//   rise       : combinational rising edge of btn (not gated by clear)
//   pulse      : combinational one-cycle request (edge, first repeat after
//                HOLD_MS ticks, then every REPEAT_MS ticks); the parent registers it
module btn_repeat
  import clock_pkg::*;
#(
  parameter int HOLD_MS   = DEF_HOLD_MS,
  parameter int REPEAT_MS = DEF_REPEAT_MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_ms,
  input  logic btn,
  input  logic clear,
  output logic rise,
  output logic pulse
);

  localparam int HW = $clog2(HOLD_MS + 1);
  localparam int RW = $clog2(REPEAT_MS + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_MS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MS - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_MS - 1);

  logic          btn_p1;
  logic          armed;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic          held_done;
  logic          hold_hit;
  logic          rep_hit;

  // armed stays low for the first cycle after reset so a button already
  // pressed at reset release is not mistaken for a fresh edge.
  assign rise      = armed & btn & ~btn_p1;
  assign held_done = (hold_cnt == HOLD_MAX);
  assign hold_hit  = btn & tick_ms & ~held_done & (hold_cnt == HOLD_LAST);
  assign rep_hit   = btn & tick_ms & held_done & (rep_cnt == REP_LAST);
  assign pulse     = ~clear & (rise | hold_hit | rep_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p1   <= 1'b0;
      armed    <= 1'b0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      btn_p1 <= btn;
      armed  <= 1'b1;
      if (clear || !btn) begin
        hold_cnt <= '0;
        rep_cnt  <= '0;
      end else if (tick_ms) begin
        // hold_cnt saturates at HOLD_MS; rep_cnt then cycles 0..REPEAT_MS-1
        if (!held_done) begin
          hold_cnt <= hold_cnt + HW'(1);
        end else if (rep_cnt == REP_LAST) begin
          rep_cnt <= '0;
        end else begin
          rep_cnt <= rep_cnt + RW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: manual time-setting sequencer for the clock counters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : time_set_controller_if.slave
//                in : tick_ms, btn_mode, btn_up, btn_down
//                out: ctrl_set_hour/min/sec (one-hot in set states),
//                     inc/dec (one-cycle pulses), field_sel (0 RUN,1 h,2 m,3 s),
//                     blink_on (display enable for the selected field)
// MODE cycles RUN->SET_HOUR->SET_MIN->SET_SEC->RUN; UP/DOWN give pulses with
// auto-repeat in set states; TIMEOUT_MS idle ticks return to RUN.
module time_set_controller
  import clock_pkg::*;
#(
  parameter int HOLD_MS    = DEF_HOLD_MS,
  parameter int REPEAT_MS  = DEF_REPEAT_MS,
  parameter int TIMEOUT_MS = DEF_TIMEOUT_MS,
  parameter int BLINK_MS   = DEF_BLINK_MS
) (
  input logic                  clk,
  input logic                  rst_n,
  time_set_controller_if.slave bus
);

  localparam int IW = $clog2(TIMEOUT_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(TIMEOUT_MS);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_MS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic          mode_p1;
  logic          mode_armed;
  logic          mode_rise;
  logic          up_rise;
  logic          up_pulse;
  logic          dn_rise;
  logic          dn_pulse;
  logic          in_set;
  logic          btn_clear;
  logic          idle_clr;
  logic          timeout;
  logic [IW-1:0] idle_cnt;
  logic [BW-1:0] blink_cnt;

  assign mode_rise = mode_armed & bus.btn_mode & ~mode_p1;
  assign in_set    = (state != ST_RUN);

  // Both buttons pressed, a MODE edge, or RUN: the hold counters restart and
  // any UP/DOWN pulse of this cycle is dropped.
  assign btn_clear = (bus.btn_up & bus.btn_down) | mode_rise | ~in_set;

  assign idle_clr = mode_rise | up_rise | dn_rise | bus.btn_up | bus.btn_down;
  assign timeout  = in_set & ~idle_clr & bus.tick_ms & (idle_cnt == IDLE_LAST);

  btn_repeat #(.HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS)) u_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_ms (bus.tick_ms),
    .btn     (bus.btn_up),
    .clear   (btn_clear),
    .rise    (up_rise),
    .pulse   (up_pulse)
  );

  btn_repeat #(.HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS)) u_down (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_ms (bus.tick_ms),
    .btn     (bus.btn_down),
    .clear   (btn_clear),
    .rise    (dn_rise),
    .pulse   (dn_pulse)
  );

  always_comb begin
    state_nx = state;
    if (mode_rise) begin
      state_nx = next_field(state);
    end else if (timeout) begin
      state_nx = ST_RUN;
    end
  end

  assign bus.field_sel = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_RUN;
      mode_p1           <= 1'b0;
      mode_armed        <= 1'b0;
      idle_cnt          <= '0;
      blink_cnt         <= '0;
      bus.blink_on      <= 1'b1;
      bus.inc           <= 1'b0;
      bus.dec           <= 1'b0;
      bus.ctrl_set_hour <= 1'b0;
      bus.ctrl_set_min  <= 1'b0;
      bus.ctrl_set_sec  <= 1'b0;
    end else begin
      state             <= state_nx;
      mode_p1           <= bus.btn_mode;
      mode_armed        <= 1'b1;
      bus.ctrl_set_hour <= (state_nx == FIELD_HOUR);
      bus.ctrl_set_min  <= (state_nx == FIELD_MIN);
      bus.ctrl_set_sec  <= (state_nx == FIELD_SEC);
      // btn_clear already blocks pulses in RUN and on MODE edges, and a pulse
      // needs its button high, so inc and dec cannot coincide.
      bus.inc           <= up_pulse;
      bus.dec           <= dn_pulse;

      if (state_nx == FIELD_RUN || idle_clr) begin
        idle_cnt <= '0;
      end else if (bus.tick_ms && idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + IW'(1);
      end

      // Blink restarts lit on RUN, on any field change and on every pulse.
      if (state_nx == FIELD_RUN || state_nx != state || up_pulse || dn_pulse) begin
        bus.blink_on <= 1'b1;
        blink_cnt    <= '0;
      end else if (bus.tick_ms) begin
        if (blink_cnt == BLINK_LAST) begin
          bus.blink_on <= ~bus.blink_on;
          blink_cnt    <= '0;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with HOLD_MS=5, REPEAT_MS=2,
// TIMEOUT_MS=20, BLINK_MS=4.
module tb_time_set_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   inc_cnt;
  int   dec_cnt;
  int   inc_base;
  int   dec_base;

  time_set_controller_if bus ();

  time_set_controller #(
    .HOLD_MS    (5),
    .REPEAT_MS  (2),
    .TIMEOUT_MS (20),
    .BLINK_MS   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    inc_cnt = 0;
    dec_cnt = 0;
  end

  always @(negedge clk) begin
    if (bus.inc === 1'b1) inc_cnt = inc_cnt + 1;
    if (bus.dec === 1'b1) dec_cnt = dec_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.tick_ms = 1'b1;
    cyc();
    bus.tick_ms = 1'b0;
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mode_press();
    bus.btn_mode = 1'b1;
    cyc();
    bus.btn_mode = 1'b0;
    cyc();
  endtask

  task automatic mark();
    inc_base = inc_cnt;
    dec_base = dec_cnt;
  endtask

  function automatic logic [31:0] ctrl_vec();
    return 32'({bus.ctrl_set_hour, bus.ctrl_set_min, bus.ctrl_set_sec});
  endfunction

  initial begin
    checks       = 0;
    errors       = 0;
    inc_base     = 0;
    dec_base     = 0;
    rst_n        = 1'b0;
    bus.tick_ms  = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b0;

    // reset with UP already pressed
    repeat (3) cyc();
    chk("rst_field", 32'(bus.field_sel), 32'd0);
    chk("rst_blink", 32'(bus.blink_on), 32'd1);
    chk("rst_incdec", 32'({bus.inc, bus.dec}), 32'd0);
    chk("rst_ctrl", ctrl_vec(), 32'd0);
    mark();
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("rel_no_inc", 32'(inc_cnt - inc_base), 32'd0);
    chk("rel_field", 32'(bus.field_sel), 32'd0);
    chk("rel_blink", 32'(bus.blink_on), 32'd1);
    bus.btn_up = 1'b0;
    cyc();

    // MODE sequencing, state valid one cycle after the sampled edge
    bus.btn_mode = 1'b1;
    cyc();
    chk("mode1_field", 32'(bus.field_sel), 32'd1);
    chk("mode1_ctrl", ctrl_vec(), 32'd4);
    bus.btn_mode = 1'b0;
    cyc();
    bus.btn_mode = 1'b1;
    cyc();
    chk("mode2_field", 32'(bus.field_sel), 32'd2);
    chk("mode2_ctrl", ctrl_vec(), 32'd2);
    bus.btn_mode = 1'b0;
    cyc();
    bus.btn_mode = 1'b1;
    cyc();
    chk("mode3_field", 32'(bus.field_sel), 32'd3);
    chk("mode3_ctrl", ctrl_vec(), 32'd1);
    bus.btn_mode = 1'b0;
    cyc();
    bus.btn_mode = 1'b1;
    cyc();
    chk("mode4_field", 32'(bus.field_sel), 32'd0);
    chk("mode4_ctrl", ctrl_vec(), 32'd0);
    bus.btn_mode = 1'b0;
    cyc();

    // SET_MIN: hold UP for 10 ticks
    mode_press();
    mode_press();
    chk("min_field", 32'(bus.field_sel), 32'd2);
    mark();
    bus.btn_up = 1'b1;
    cyc();
    chk("edge_inc_now", 32'(bus.inc), 32'd1);
    cyc();
    chk("edge_inc_once", 32'(bus.inc), 32'd0);
    ticks(4);
    chk("hold_pre_cnt", 32'(inc_cnt - inc_base), 32'd1);
    bus.tick_ms = 1'b1;
    cyc();
    chk("hold_first_rep", 32'(bus.inc), 32'd1);
    bus.tick_ms = 1'b0;
    cyc();
    chk("hold_first_rep_end", 32'(bus.inc), 32'd0);
    ticks(5);
    bus.btn_up = 1'b0;
    repeat (3) cyc();
    chk("hold_inc_total", 32'(inc_cnt - inc_base), 32'd4);
    chk("hold_no_dec", 32'(dec_cnt - dec_base), 32'd0);
    chk("hold_field", 32'(bus.field_sel), 32'd2);

    // SET_HOUR: DOWN, then both, then UP released
    mode_press();
    mode_press();
    mode_press();
    chk("hour_field", 32'(bus.field_sel), 32'd1);
    mark();
    bus.btn_down = 1'b1;
    repeat (2) cyc();
    chk("down_edge", 32'(dec_cnt - dec_base), 32'd1);
    bus.btn_up = 1'b1;
    cyc();
    ticks(8);
    chk("both_no_inc", 32'(inc_cnt - inc_base), 32'd0);
    chk("both_no_dec", 32'(dec_cnt - dec_base), 32'd1);
    bus.btn_up = 1'b0;
    cyc();
    ticks(4);
    chk("rel_up_wait", 32'(dec_cnt - dec_base), 32'd1);
    bus.tick_ms = 1'b1;
    cyc();
    chk("rel_up_dec", 32'(bus.dec), 32'd1);
    bus.tick_ms = 1'b0;
    cyc();
    chk("rel_up_dec_cnt", 32'(dec_cnt - dec_base), 32'd2);
    chk("rel_up_no_inc", 32'(inc_cnt - inc_base), 32'd0);
    bus.btn_down = 1'b0;
    cyc();

    // blink: lit after the pulse, toggles every 4 ticks
    ticks(3);
    chk("blink_still_on", 32'(bus.blink_on), 32'd1);
    tick();
    chk("blink_off", 32'(bus.blink_on), 32'd0);
    ticks(4);
    chk("blink_on_again", 32'(bus.blink_on), 32'd1);

    // timeout from SET_SEC with no buttons
    mode_press();
    mode_press();
    chk("sec_field", 32'(bus.field_sel), 32'd3);
    ticks(19);
    chk("to_before", 32'(bus.field_sel), 32'd3);
    bus.tick_ms = 1'b1;
    cyc();
    chk("to_field", 32'(bus.field_sel), 32'd0);
    chk("to_ctrl", ctrl_vec(), 32'd0);
    chk("to_blink", 32'(bus.blink_on), 32'd1);
    bus.tick_ms = 1'b0;
    cyc();

    // timeout restarted by an UP press after tick 15
    mode_press();
    mode_press();
    mode_press();
    chk("sec2_field", 32'(bus.field_sel), 32'd3);
    ticks(15);
    bus.btn_up = 1'b1;
    cyc();
    bus.btn_up = 1'b0;
    cyc();
    ticks(19);
    chk("to2_before", 32'(bus.field_sel), 32'd3);
    bus.tick_ms = 1'b1;
    cyc();
    chk("to2_field", 32'(bus.field_sel), 32'd0);
    bus.tick_ms = 1'b0;
    cyc();

    // MODE and UP edges together in SET_HOUR
    mode_press();
    chk("hour2_field", 32'(bus.field_sel), 32'd1);
    mark();
    bus.btn_mode = 1'b1;
    bus.btn_up   = 1'b1;
    cyc();
    chk("mode_up_field", 32'(bus.field_sel), 32'd2);
    bus.btn_mode = 1'b0;
    repeat (2) cyc();
    chk("mode_up_no_inc", 32'(inc_cnt - inc_base), 32'd0);
    ticks(4);
    chk("mode_up_hold_wait", 32'(inc_cnt - inc_base), 32'd0);
    tick();
    chk("mode_up_full_hold", 32'(inc_cnt - inc_base), 32'd1);

    // asynchronous reset in the middle of a pulse
    bus.btn_up = 1'b0;
    cyc();
    bus.btn_up = 1'b1;
    cyc();
    chk("pre_rst_inc", 32'(bus.inc), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_inc", 32'(bus.inc), 32'd0);
    chk("async_field", 32'(bus.field_sel), 32'd0);
    chk("async_ctrl", ctrl_vec(), 32'd0);
    chk("async_blink", 32'(bus.blink_on), 32'd1);
    bus.btn_up = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("post_rst_field", 32'(bus.field_sel), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
